// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if : start/busy/done handshake bundle for muldiv_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, funct3, a, b, input busy, done, result);
  modport slave  (input start, kill, funct3, a, b, output busy, done, result);
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit : iterative RV32M/RV64M multiply/divide, one bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);

  localparam int             CW       = $clog2(XLEN);
  localparam logic [CW-1:0]  CNT_INIT = CW'(XLEN - 1);
  localparam logic [1:0]     IDLE     = 2'd0;
  localparam logic [1:0]     CALC     = 2'd1;
  localparam logic [1:0]     FIX      = 2'd2;
  localparam logic [1:0]     DONE     = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic              r_rem_neg;
  logic              r_fast;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_result;

  // Operand decode at acceptance
  logic            w_a_signed, w_b_signed, w_sa, w_sb;
  logic [XLEN-1:0] w_amag, w_bmag;
  logic            w_b_zero, w_ovf, w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
  assign w_sa       = w_a_signed & bus.a[XLEN-1];
  assign w_sb       = w_b_signed & bus.b[XLEN-1];
  assign w_amag     = w_sa ? -bus.a : bus.a;
  assign w_bmag     = w_sb ? -bus.b : bus.b;
  assign w_b_zero   = (bus.b == '0);
  assign w_ovf      = bus.funct3[2] & ~bus.funct3[0] &
                      (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
  assign w_fast     = bus.funct3[2] & (w_b_zero | w_ovf);
  assign w_fast_res = w_b_zero ? (bus.funct3[1] ? bus.a : '1)
                               : (bus.funct3[1] ? '0 : bus.a);

  // Shift-add multiply step: multiplier sits in the low half and drains right
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:1]};

  // Restoring divide step: remainder in the high half, quotient shifts in low
  logic [XLEN:0]     w_shift;
  logic              w_geq;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_div_next;
  assign w_shift    = r_acc[2*XLEN-1:XLEN-1];
  assign w_geq      = (w_shift >= {1'b0, r_mcand});
  assign w_diff     = w_shift[XLEN-1:0] - r_mcand;
  assign w_div_next = {(w_geq ? w_diff : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_geq};

  // Sign correction and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q, w_r, w_quo, w_rem, w_fix_res;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_q    = r_acc[XLEN-1:0];
  assign w_r    = r_acc[2*XLEN-1:XLEN];
  assign w_quo  = r_neg ? -w_q : w_q;
  assign w_rem  = r_rem_neg ? -w_r : w_r;

  always_comb begin
    w_fix_res = '0;
    if (r_fast)
      w_fix_res = r_acc[XLEN-1:0];
    else if (!r_op[2])
      w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else
      w_fix_res = r_op[1] ? w_rem : w_quo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_fast    <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_result  <= '0;
    end else if (bus.kill) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op      <= bus.funct3;
            r_neg     <= w_sa ^ w_sb;
            r_rem_neg <= w_sa;
            r_fast    <= w_fast;
            r_cnt     <= CNT_INIT;
            // Fast results park in FIX for one cycle so done lands at E1
            if (w_fast) begin
              r_acc   <= {{XLEN{1'b0}}, w_fast_res};
              r_state <= FIX;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, (bus.funct3[2] ? w_amag : w_bmag)};
              r_mcand <= bus.funct3[2] ? w_bmag : w_amag;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          if (r_cnt == '0)
            r_state <= FIX;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_result <= w_fix_res;
          r_state  <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.result = r_result;

endmodule

`default_nettype wire
